// File: rtl/dda_pkg.sv
// Shared definitions for the DDA run sequencer.
//   - default word/parameter-file sizes
//   - command opcodes
//   - sequencer state encoding
//   - parameter-file reset value
//   - run-length decode helper
package dda_pkg;

    localparam int DDA_N        = 16;
    localparam int DDA_REG_SIZE = 14;
    localparam int DDA_OUT_SIZE = 6;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_RUN    = 8'h02;
    localparam logic [7:0] OP_RELOAD = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ARG     = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5
    } seq_state_e;

    // icx=-1, icy=0.1, icz=25, sigma=10, beta=8/3, rho=28, dt=1/256 (posit16, MSB byte first)
    localparam logic [DDA_REG_SIZE*8-1:0] PARAMS_DEFAULT =
        112'hC000_14CD_7240_6A00_5555_7300_0400;

    // A run argument of zero means the longest run.
    function automatic logic [8:0] run_length(input logic [7:0] k);
        return (k == 8'd0) ? 9'd256 : {1'b0, k};
    endfunction

endpackage

// File: rtl/dda_snapshot_tx.sv
// Snapshot latch and byte serialiser for the DDA state vector.
// On 'capture' it latches {x,y,z} and then presents the frame one byte at a time,
// MSB byte of x first, advancing only on tx_valid && tx_ready.
// Optional feature macro: DDA_SEQ_CHECKSUM_EN appends one byte holding the XOR
// of all snapshot bytes.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   capture        1-cycle strobe: latch x/y/z and start a frame
//   x, y, z        DDA state words
//   tx_data/valid  byte stream out
//   tx_ready       sink ready
//   done           high on the handshake of the final frame byte
module dda_snapshot_tx
    import dda_pkg::*;
#(
    parameter int N        = DDA_N,
    parameter int OUT_SIZE = DDA_OUT_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         done
);

`ifdef DDA_SEQ_CHECKSUM_EN
    localparam int FRAME_SIZE = OUT_SIZE + 1;
`else
    localparam int FRAME_SIZE = OUT_SIZE;
`endif
    localparam int IDX_W = $clog2(FRAME_SIZE);

    logic [3*N-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             active_q, active_d;
    logic [7:0]       cur_byte;
    logic             handshake;
`ifdef DDA_SEQ_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cur_byte = '0;
`ifdef DDA_SEQ_CHECKSUM_EN
        checksum = '0;
`endif
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_byte = snap_q[3*N-1-8*i -: 8];
            end
`ifdef DDA_SEQ_CHECKSUM_EN
            checksum = checksum ^ snap_q[3*N-1-8*i -: 8];
`endif
        end
`ifdef DDA_SEQ_CHECKSUM_EN
        if (idx_q == IDX_W'(OUT_SIZE)) begin
            cur_byte = checksum;
        end
`endif
    end

    assign handshake = active_q && tx_ready;
    assign done      = handshake && (idx_q == IDX_W'(FRAME_SIZE - 1));
    assign tx_valid  = active_q;
    assign tx_data   = cur_byte;

    always_comb begin
        snap_d   = snap_q;
        idx_d    = idx_q;
        active_d = active_q;
        if (capture) begin
            snap_d   = {x, y, z};
            idx_d    = '0;
            active_d = 1'b1;
        end else if (handshake) begin
            if (done) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    // NOTE: the snapshot data register has no reset; it is always written by capture before it is read.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

endmodule

// File: rtl/dda_run_sequencer.sv
// Byte-command controller for the Lorenz DDA integrator.
// Opcodes in IDLE: 0x01 LOAD (14 parameter bytes), 0x02 RUN (one length byte,
// 0 = 256 cycles), 0x03 RELOAD (pulse dda_load). After a run the x/y/z
// snapshot is streamed out through dda_snapshot_tx.
// Optional feature macro: DDA_SEQ_CHECKSUM_EN (adds an XOR byte to each frame).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_data/valid/ready       command byte stream in
//   tx_data/valid/ready       snapshot byte stream out
//   x, y, z                   DDA state words
//   dda_en                    integrator enable
//   dda_load                  1-cycle reload pulse
//   params                    parameter file, byte 0 in the top byte
//   busy                      state != IDLE
//   cmd_err                   1-cycle pulse on an unknown opcode
module dda_run_sequencer
    import dda_pkg::*;
#(
    parameter int N        = DDA_N,
    parameter int REG_SIZE = DDA_REG_SIZE,
    parameter int OUT_SIZE = DDA_OUT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [N-1:0]          x,
    input  logic [N-1:0]          y,
    input  logic [N-1:0]          z,
    output logic                  dda_en,
    output logic                  dda_load,
    output logic [REG_SIZE*8-1:0] params,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int PW    = REG_SIZE * 8;
    localparam int CNT_W = $clog2(REG_SIZE);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [8:0]       run_cnt_q, run_cnt_d;
    logic [PW-1:0]    params_q, params_d;
    logic [PW-9:0]    shadow_q, shadow_d;   // first REG_SIZE-1 bytes of a LOAD
    logic             load_pulse_q, load_pulse_d;
    logic             cmd_err_q, cmd_err_d;
    logic             capture;
    logic             tx_done;
    logic             rx_fire;

    assign rx_fire = rx_valid && rx_ready;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        run_cnt_d    = run_cnt_q;
        params_d     = params_q;
        shadow_d     = shadow_q;
        load_pulse_d = 1'b0;
        cmd_err_d    = 1'b0;
        rx_ready     = 1'b0;
        dda_en       = 1'b0;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    case (rx_data)
                        OP_LOAD: begin
                            state_d    = ST_LOAD;
                            byte_cnt_d = '0;
                        end
                        OP_RUN:    state_d      = ST_ARG;
                        OP_RELOAD: load_pulse_d = 1'b1;
                        default:   cmd_err_d    = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    shadow_d = {shadow_q[PW-17:0], rx_data};
                    if (byte_cnt_q == CNT_W'(REG_SIZE - 1)) begin
                        // Whole file committed in one cycle: params never show a partial load.
                        params_d     = {shadow_q, rx_data};
                        load_pulse_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_ARG: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    run_cnt_d = run_length(rx_data);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                dda_en = 1'b1;
                if (run_cnt_q == 9'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    run_cnt_d = run_cnt_q - 9'd1;
                end
            end
            ST_CAPTURE: begin
                // First cycle with dda_en low: x/y/z reflect the completed run.
                capture = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            run_cnt_q    <= '0;
            params_q     <= PARAMS_DEFAULT;
            load_pulse_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            run_cnt_q    <= run_cnt_d;
            params_q     <= params_d;
            load_pulse_q <= load_pulse_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    dda_snapshot_tx #(
        .N        (N),
        .OUT_SIZE (OUT_SIZE)
    ) u_snapshot_tx (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .x        (x),
        .y        (y),
        .z        (z),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done)
    );

    assign params   = params_q;
    assign dda_load = load_pulse_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dda_run_sequencer.sv
module tb_dda_run_sequencer;

    localparam int N        = 16;
    localparam int REG_SIZE = 14;
`ifdef DDA_SEQ_CHECKSUM_EN
    localparam int FRAME = 7;
`else
    localparam int FRAME = 6;
`endif
    localparam logic [111:0] DEF_PARAMS = 112'hC00014CD72406A00555573000400;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_valid = 1'b0;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready = 1'b1;
    logic [N-1:0]          x = '0, y = '0, z = '0;
    logic                  dda_en, dda_load, busy, cmd_err;
    logic [REG_SIZE*8-1:0] params;

    dda_run_sequencer dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .x(x), .y(y), .z(z),
        .dda_en(dda_en), .dda_load(dda_load), .params(params),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- passive monitor (sampled on the falling edge) ----------------
    int         cyc = 0, en_cnt = 0, load_cnt = 0, err_cnt = 0;
    int         en_rise = -1, en_fall = -1, txv_rise = -1;
    int         stall_viol = 0, overlap_viol = 0, rx_viol = 0;
    int         tx_n = 0;
    logic [7:0] tx_log [0:4095];
    logic       prev_en = 1'b0, prev_txv = 1'b0, stalled = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_en  <= 1'b0;
            prev_txv <= 1'b0;
            stalled  <= 1'b0;
        end else begin
            prev_en  <= dda_en;
            prev_txv <= tx_valid;
            if (dda_en) begin
                en_cnt  <= en_cnt + 1;
                en_fall <= cyc + 1;
                if (!prev_en) en_rise <= cyc + 1;
            end
            if (tx_valid && !prev_txv) txv_rise <= cyc + 1;
            if (dda_load) load_cnt <= load_cnt + 1;
            if (cmd_err) err_cnt <= err_cnt + 1;
            if (dda_en && dda_load) overlap_viol <= overlap_viol + 1;
            if ((dda_en || tx_valid) && rx_ready) rx_viol <= rx_viol + 1;
            if (tx_valid && tx_ready) begin
                tx_log[tx_n] <= tx_data;
                tx_n <= tx_n + 1;
            end
            if (stalled && (!tx_valid || tx_data !== held)) stall_viol <= stall_viol + 1;
            stalled <= tx_valid && !tx_ready;
            held    <= tx_data;
        end
    end

    // ---------------- sink ready driver ----------------
    logic rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx_valid/rx_data must already be set; returns just after the accepting edge.
    task automatic wait_accept();
        logic rdy;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rdy = rx_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!ok) check("rx_accept_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        wait_accept();
    endtask

    logic [111:0] pm = DEF_PARAMS;   // parameter-file model

    task automatic do_load(input logic [7:0] b [14], input int abort_after);
        logic [111:0] np;
        int base;
        base = load_cnt;
        send_byte(8'h01);
        for (int i = 0; i < 14; i++) begin
            if (i == abort_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_params_default", params, DEF_PARAMS);
                check("abort_busy", busy, 0);
                pm = DEF_PARAMS;
                return;
            end
            if (i == 13) check("load_no_partial_update", params, pm);
            send_byte(b[i]);
            np[111 - 8*i -: 8] = b[i];
        end
        pm = np;
        check("load_params", params, pm);
        check("load_pulse_next_cycle", dda_load, 1);
        tick();
        check("load_pulse_width", dda_load, 0);
        tick();
        check("load_pulse_count", load_cnt - base, 1);
        check("load_idle", busy, 0);
    endtask

    task automatic run_check(input logic [7:0] k, input logic [15:0] xv, input logic [15:0] yv,
                             input logic [15:0] zv, input logic rnd, input logic hold_rx);
        int         c, len, base_en, base_tx, base_ld;
        logic [7:0] exp [FRAME];
        logic [15:0] w [3];
        logic [7:0] cs;
        x = xv; y = yv; z = zv;
        w[0] = xv; w[1] = yv; w[2] = zv;
        cs = 8'h00;
        for (int i = 0; i < 3; i++) begin
            exp[2*i]   = w[i][15:8];
            exp[2*i+1] = w[i][7:0];
            cs = cs ^ w[i][15:8] ^ w[i][7:0];
        end
`ifdef DDA_SEQ_CHECKSUM_EN
        exp[6] = cs;
`endif
        len     = (k == 8'd0) ? 256 : int'(k);
        rand_ready = rnd;
        base_en = en_cnt;
        base_tx = tx_n;
        base_ld = load_cnt;
        send_byte(8'h02);
        c = cyc;
        send_byte(k);
        if (hold_rx) begin
            rx_data  = 8'h03;
            rx_valid = 1'b1;
        end
        for (int i = 0; i < 1500 && tx_n < base_tx + FRAME; i++) tick();
        rand_ready = 1'b0;
        check($sformatf("run_k%0d_frame_len", k), tx_n - base_tx, FRAME);
        check($sformatf("run_k%0d_en_cycles", k), en_cnt - base_en, len);
        check($sformatf("run_k%0d_en_contig", k), en_fall - en_rise + 1, len);
        check($sformatf("run_k%0d_en_start", k), en_rise, c + 2);
        check($sformatf("run_k%0d_first_txv", k), txv_rise, c + 3 + len);
        for (int i = 0; i < FRAME; i++)
            check($sformatf("run_k%0d_byte%0d", k, i), tx_log[base_tx + i], exp[i]);
        check($sformatf("run_k%0d_idle", k), busy, 0);
        if (hold_rx) begin
            wait_accept();
            check("held_byte_accepted_after_run", dda_load, 1);
            check("held_byte_no_early_load", load_cnt - base_ld, 0);
        end
    endtask

    typedef struct {
        logic [7:0] op;
        logic       exp_err;
        logic       exp_load;
    } cmd_vec_t;

    cmd_vec_t   vecs [6];
    logic [7:0] lb [14];

    initial begin
        vecs[0] = '{8'h7F, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h04, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0};

        // reset state
        tick(); tick(); tick();
        rst = 1'b0;
        check("reset_params", params, DEF_PARAMS);
        check("reset_dda_en", dda_en, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_cmd_err", cmd_err, 0);
        check("reset_dda_load", dda_load, 0);
        check("reset_rx_ready", rx_ready, 1);

        // opcode decode table
        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].op);
            check($sformatf("op%02h_cmd_err", vecs[v].op), cmd_err, vecs[v].exp_err);
            check($sformatf("op%02h_dda_load", vecs[v].op), dda_load, vecs[v].exp_load);
            tick();
            check($sformatf("op%02h_pulse_end", vecs[v].op), {cmd_err, dda_load}, 2'b00);
            check($sformatf("op%02h_busy", vecs[v].op), busy, 0);
            check($sformatf("op%02h_params", vecs[v].op), params, pm);
        end

        // LOAD 00..0D
        for (int i = 0; i < 14; i++) lb[i] = 8'(i);
        do_load(lb, -1);
        check("load_seq_params", params, 112'h000102030405060708090A0B0C0D);

        // basic run, then k=0 with random sink stalls
        run_check(8'h05, 16'h1234, 16'h5678, 16'h9ABC, 1'b0, 1'b0);
        run_check(8'h00, 16'hDEAD, 16'hBEEF, 16'h0F1E, 1'b1, 1'b0);

        // rx byte held through RUN/SEND is only taken once back in IDLE
        run_check(8'h03, 16'hA5A5, 16'h5A5A, 16'h00FF, 1'b1, 1'b1);

        // reset part-way through a LOAD, then a short run
        for (int i = 0; i < 14; i++) lb[i] = 8'hF0 + 8'(i);
        do_load(lb, 7);
        run_check(8'h01, 16'h0102, 16'h0304, 16'h0506, 1'b0, 1'b0);

        // randomized commands against the model
        for (int it = 0; it < 10; it++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                for (int i = 0; i < 14; i++) lb[i] = 8'($urandom);
                do_load(lb, -1);
            end else if (sel == 1) begin
                logic [7:0] op;
                int e0;
                op = 8'($urandom_range(4, 255));
                e0 = err_cnt;
                send_byte(op);
                tick(); tick();
                check("rand_bad_op_err", err_cnt - e0, 1);
                check("rand_bad_op_params", params, pm);
            end else begin
                run_check(8'($urandom_range(1, 40)), 16'($urandom), 16'($urandom),
                          16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        check("no_tx_change_while_stalled", stall_viol, 0);
        check("no_en_load_overlap", overlap_viol, 0);
        check("no_rx_ready_in_run_send", rx_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
